// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings, types and lane helpers for data_mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lane;
    logic [31:0] raw;
  } rsp_stage_t;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{wdata[7:0]}};
      SZ_HALF: w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] size,
                                               input logic uns, input logic [1:0] lane);
    logic [31:0] sh;
    logic [31:0] r;
    sh = raw >> {lane, 3'b000};
    case (size)
      SZ_BYTE: r = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_HALF: r = {{16{~uns & sh[15]}}, sh[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_rsp_pipe.sv
// ============================================================================
// Module      : dmem_rsp_pipe
// Description : Fixed-latency response shift register, flushed on reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_rsp_pipe
  import dmem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  rsp_stage_t in_stage,
  output rsp_stage_t out_stage
);

  rsp_stage_t stage_q [LATENCY];
  rsp_stage_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = in_stage;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_stage = stage_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-lane data memory with valid/ready requests, fixed-latency
//               in-order responses, error flagging and optional clear-on-reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 1024,
  parameter int          READ_LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  CNT_LAST = AW'(DEPTH_WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_we;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          w_accept;
  logic [31:0]   w_offset;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  rsp_stage_t    w_pipe_in;
  rsp_stage_t    w_pipe_out;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = ~reset;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready is held low in the reset cycle even if the state register still says RUN.
  assign req_ready = (state_q == ST_RUN) && !reset;
  assign w_accept  = req_valid && req_ready;

  // BASE_ADDR is aligned to the array size, so offset low bits equal the address lane.
  assign w_offset = req_addr - BASE_ADDR;
  assign w_idx    = w_offset[AW+1:2];
  assign w_err    = (|w_offset[31:AW+2])
                  || (req_size == SZ_HALF && w_offset[0])
                  || (req_size == SZ_WORD && w_offset[1:0] != 2'b00)
                  || (req_size == SZ_ILL);
  assign w_be     = byte_en(req_size, w_offset[1:0]);
  assign w_wdata  = store_lanes(req_size, req_wdata);

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (w_accept && req_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_pipe_in       = '0;
    w_pipe_in.valid = w_accept;
    w_pipe_in.error = w_accept && w_err;
    w_pipe_in.size  = req_size;
    w_pipe_in.uns   = req_unsigned;
    w_pipe_in.lane  = w_offset[1:0];
    // Stores and errored requests carry a zero word so they extract to zero.
    if (w_accept && !req_write && !w_err) w_pipe_in.raw = mem_q[w_idx];
  end

  dmem_rsp_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rsp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_stage  (w_pipe_in),
    .out_stage (w_pipe_out)
  );

  assign rsp_valid = w_pipe_out.valid && !reset;
  assign rsp_error = rsp_valid && w_pipe_out.error;
  assign rsp_rdata = (rsp_valid && !w_pipe_out.error)
                   ? load_extract(w_pipe_out.raw, w_pipe_out.size, w_pipe_out.uns, w_pipe_out.lane)
                   : 32'h0;

endmodule

`default_nettype wire
